uart_program_loader: RTL and testbench

Sequencer that sits downstream of the UART byte receiver and loads a program image into instruction memory. It parses a framed byte stream (sync, word count, little-endian words, XOR checksum) and assembles 32-bit words. It issues single-cycle memory write strobes and holds the CPU in reset until a frame has been received with a valid checksum. It also detects inter-byte timeouts and oversize images.

---
 rtl/uart_program_loader.sv | 271 +++++++++++++++++++++++++++
 tb/tb_uart_program_loader.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_program_loader.sv
// ---------------------------------------------------------------------------
// uart_program_loader
//
// Sits behind the UART byte receiver and loads a program image into
// instruction memory. The byte stream is framed as:
//
//   SYNC_BYTE, CNT_LO, CNT_HI, N x (4 bytes, LSB first), CHK
//
// where N = {CNT_HI, CNT_LO} and CHK is the XOR of the two count bytes and
// every data byte. Each completed 32-bit word is written to memory right
// away with a one-cycle strobe. The CPU is held in reset from the moment a
// frame starts until a frame finishes with a matching checksum. Frames that
// are too large for the memory, stall between bytes, or carry a bad checksum
// raise load_error and leave the CPU in reset.
//
// Parameters
//   ADDR_W        word-address width; largest image is 2**ADDR_W words
//   TIMEOUT_CLKS  maximum clocks allowed between bytes inside a frame
//   SYNC_BYTE     frame start marker
//
// Ports
//   clk            single clock, rising edge
//   rst            synchronous active-high reset
//   byte_received  one-cycle pulse, rx_byte valid in that cycle
//   rx_byte        received byte
//   mem_we         one-cycle instruction-memory write strobe
//   mem_addr       word address of the write (held until the next write)
//   mem_wdata      write data (held until the next write)
//   cpu_reset      high while the CPU must stay in reset
//   load_done      sticky: last frame completed with a good checksum
//   load_error     sticky: last frame failed
// ---------------------------------------------------------------------------
module uart_program_loader #(
  parameter int          ADDR_W       = 10,
  parameter int          TIMEOUT_CLKS = 434000,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              byte_received,
  input  logic [7:0]        rx_byte,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_reset,
  output logic              load_done,
  output logic              load_error
);

  typedef enum logic [2:0] {
    ST_SYNC,
    ST_CNT_LO,
    ST_CNT_HI,
    ST_DATA,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } state_t;

  // Word counts are compared one bit wider than the count field so that
  // 2**ADDR_W itself is representable for any ADDR_W up to 16.
  localparam logic [16:0] MAX_WORDS    = 17'(2 ** ADDR_W);
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CLKS - 1);

  state_t              state;
  state_t              next_state;

  logic [7:0]          cnt_lo;
  logic [ADDR_W-1:0]   last_idx;
  logic [ADDR_W-1:0]   word_idx;
  logic [1:0]          lane;
  logic [23:0]         shift_data;
  logic [7:0]          chk_acc;
  logic [31:0]         idle_cnt;

  logic [15:0]         count_in;
  logic                counting;
  logic                timeout;
  logic                is_sync;

  logic                start_frame;
  logic                latch_lo;
  logic                start_data;
  logic                take_data;
  logic                acc_byte;
  logic                do_write;
  logic                set_done;
  logic                set_error;

  // Full word count as seen while the high count byte is on rx_byte.
  assign count_in = {rx_byte, cnt_lo};

  // The inter-byte timer only runs while a frame is in progress. A byte in
  // the same cycle as an expiring timer takes priority.
  assign counting = (state == ST_CNT_LO) || (state == ST_CNT_HI) ||
                    (state == ST_DATA)   || (state == ST_CHECK);
  assign timeout  = counting && !byte_received && (idle_cnt >= TIMEOUT_LAST);
  assign is_sync  = byte_received && (rx_byte == SYNC_BYTE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_SYNC;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic and the control strobes that drive the datapath.
  always_comb begin
    next_state  = state;
    start_frame = 1'b0;
    latch_lo    = 1'b0;
    start_data  = 1'b0;
    take_data   = 1'b0;
    acc_byte    = 1'b0;
    do_write    = 1'b0;
    set_done    = 1'b0;
    set_error   = 1'b0;

    case (state)
      // Idle and loaded states behave identically on a sync byte, so a
      // reload after a good frame puts the CPU straight back into reset.
      ST_SYNC, ST_DONE: begin
        if (is_sync) begin
          start_frame = 1'b1;
          next_state  = ST_CNT_LO;
        end
      end

      ST_CNT_LO: begin
        if (byte_received) begin
          latch_lo   = 1'b1;
          acc_byte   = 1'b1;
          next_state = ST_CNT_HI;
        end else if (timeout) begin
          next_state = ST_ERROR;
        end
      end

      ST_CNT_HI: begin
        if (byte_received) begin
          acc_byte = 1'b1;
          if ({1'b0, count_in} > MAX_WORDS) begin
            next_state = ST_ERROR;
          end else if (count_in == 16'd0) begin
            next_state = ST_CHECK;
          end else begin
            start_data = 1'b1;
            next_state = ST_DATA;
          end
        end else if (timeout) begin
          next_state = ST_ERROR;
        end
      end

      ST_DATA: begin
        if (byte_received) begin
          take_data = 1'b1;
          acc_byte  = 1'b1;
          if (lane == 2'd3) begin
            do_write = 1'b1;
            if (word_idx == last_idx) begin
              next_state = ST_CHECK;
            end
          end
        end else if (timeout) begin
          next_state = ST_ERROR;
        end
      end

      ST_CHECK: begin
        if (byte_received) begin
          if (rx_byte == chk_acc) begin
            set_done   = 1'b1;
            next_state = ST_DONE;
          end else begin
            next_state = ST_ERROR;
          end
        end else if (timeout) begin
          next_state = ST_ERROR;
        end
      end

      // Single-cycle state: flag the failure and go back to hunting for sync.
      ST_ERROR: begin
        set_error  = 1'b1;
        next_state = ST_SYNC;
      end

      default: begin
        next_state = ST_SYNC;
      end
    endcase
  end

  // Datapath: count/word tracking, word assembly, checksum, timer and the
  // registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_reset  <= 1'b1;
      load_done  <= 1'b0;
      load_error <= 1'b0;
      cnt_lo     <= '0;
      last_idx   <= '0;
      word_idx   <= '0;
      lane       <= '0;
      shift_data <= '0;
      chk_acc    <= '0;
      idle_cnt   <= '0;
    end else begin
      mem_we <= do_write;

      // Lanes 0..2 sit in shift_data; lane 3 comes straight off rx_byte.
      if (do_write) begin
        mem_addr  <= word_idx;
        mem_wdata <= {rx_byte, shift_data};
      end

      if (start_frame) begin
        chk_acc    <= '0;
        load_done  <= 1'b0;
        load_error <= 1'b0;
        cpu_reset  <= 1'b1;
      end else if (acc_byte) begin
        chk_acc <= chk_acc ^ rx_byte;
      end

      if (latch_lo) begin
        cnt_lo <= rx_byte;
      end

      // N is at least 1 here and at most 2**ADDR_W, so N-1 fits the
      // word index exactly and addresses never wrap.
      if (start_data) begin
        last_idx <= ADDR_W'(count_in - 16'd1);
        word_idx <= '0;
        lane     <= '0;
      end

      if (take_data) begin
        lane       <= lane + 2'd1;
        shift_data <= {rx_byte, shift_data[23:8]};
        if (do_write) begin
          word_idx <= word_idx + 1'b1;
        end
      end

      if (set_done) begin
        load_done <= 1'b1;
        cpu_reset <= 1'b0;
      end

      if (set_error) begin
        load_error <= 1'b1;
        cpu_reset  <= 1'b1;
      end

      // Saturating inter-byte timer; held at zero outside a frame.
      if (!counting || byte_received) begin
        idle_cnt <= '0;
      end else if (idle_cnt != 32'hFFFF_FFFF) begin
        idle_cnt <= idle_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_program_loader.sv
// ---------------------------------------------------------------------------
// tb_uart_program_loader
//
// Self-checking bench for uart_program_loader (ADDR_W=4, short timeout).
// A table of byte streams with their expected flags and write counts is
// replayed back-to-back, a handful of hand-written sequences cover exact
// write/done timing, timeout, oversize and mid-word reset, and randomised
// multi-frame sessions are compared against a byte-stream reference model
// that parses frames directly from the framing rules.
// ---------------------------------------------------------------------------
module tb_uart_program_loader;

  localparam int         ADDR_W       = 4;
  localparam int         TIMEOUT_CLKS = 60;
  localparam logic [7:0] SYNC         = 8'hA5;
  localparam int         MAX_WORDS    = 2 ** ADDR_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              byte_received = 1'b0;
  logic [7:0]        rx_byte = 8'h00;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_reset;
  logic              load_done;
  logic              load_error;

  always #5 clk = ~clk;

  uart_program_loader #(
    .ADDR_W       (ADDR_W),
    .TIMEOUT_CLKS (TIMEOUT_CLKS),
    .SYNC_BYTE    (SYNC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .byte_received (byte_received),
    .rx_byte       (rx_byte),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .cpu_reset     (cpu_reset),
    .load_done     (load_done),
    .load_error    (load_error)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    string        name;
    int           nbytes;
    logic [127:0] data;
    int           exp_writes;
    logic         exp_done;
    logic         exp_error;
    logic         exp_cpu_reset;
  } vec_t;

  wr_t  write_q[$];
  wr_t  mon_w;
  vec_t vecs[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Capture every write strobe away from the active edge.
  always @(negedge clk) begin
    if (mem_we) begin
      mon_w.addr = 32'(mem_addr);
      mon_w.data = mem_wdata;
      write_q.push_back(mon_w);
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Pulse one byte (caller is at a negedge) then idle for gap cycles.
  task automatic applyStimulus(input logic [7:0] b, input int gap);
    byte_received = 1'b1;
    rx_byte       = b;
    @(negedge clk);
    byte_received = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic applyReset();
    byte_received = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_mem_we"},     32'(mem_we),     32'd0);
    checkOutput({tag, "_mem_addr"},   32'(mem_addr),   32'd0);
    checkOutput({tag, "_mem_wdata"},  mem_wdata,       32'd0);
    checkOutput({tag, "_cpu_reset"},  32'(cpu_reset),  32'd1);
    checkOutput({tag, "_load_done"},  32'(load_done),  32'd0);
    checkOutput({tag, "_load_error"}, 32'(load_error), 32'd0);
  endtask

  // Reference model: walks a byte stream (starting from reset) frame by
  // frame, producing the expected writes, final flags and the positions of
  // bytes whose arrival makes the frame fail.
  task automatic modelRun(input logic [7:0] s[$], output wr_t exp_q[$],
                          output logic done, output logic err,
                          output logic cr, output int err_idx[$]);
    int         i;
    int         n;
    logic [7:0] x;
    wr_t        wr;
    bit         truncated;
    exp_q   = {};
    err_idx = {};
    done = 1'b0;
    err  = 1'b0;
    cr   = 1'b1;
    i    = 0;
    while (i < s.size()) begin
      if (s[i] != SYNC) begin
        i++;
        continue;
      end
      done = 1'b0;
      err  = 1'b0;
      cr   = 1'b1;
      i++;
      if (i + 2 > s.size()) break;
      n = int'({s[i+1], s[i]});
      x = s[i] ^ s[i+1];
      i += 2;
      if (n > MAX_WORDS) begin
        err = 1'b1;
        err_idx.push_back(i - 1);
        continue;
      end
      truncated = 1'b0;
      for (int w = 0; w < n; w++) begin
        if (i + 4 > s.size()) begin
          truncated = 1'b1;
          break;
        end
        wr.addr = 32'(w);
        wr.data = {s[i+3], s[i+2], s[i+1], s[i]};
        x = x ^ s[i] ^ s[i+1] ^ s[i+2] ^ s[i+3];
        exp_q.push_back(wr);
        i += 4;
      end
      if (truncated || i >= s.size()) break;
      if (s[i] == x) begin
        done = 1'b1;
        cr   = 1'b0;
      end else begin
        err = 1'b1;
        err_idx.push_back(i);
      end
      i++;
    end
  endtask

  // Drive a stream with random gaps (at least one idle cycle after a byte
  // that fails a frame) and compare everything against the model.
  task automatic runStream(input logic [7:0] s[$], input int max_gap,
                           input string tag);
    wr_t  exp_q[$];
    int   err_idx[$];
    logic d, e, c;
    int   gap;
    modelRun(s, exp_q, d, e, c, err_idx);
    write_q.delete();
    foreach (s[i]) begin
      gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      foreach (err_idx[k]) begin
        if (err_idx[k] == i && gap == 0) gap = 1;
      end
      applyStimulus(s[i], gap);
    end
    repeat (3) @(negedge clk);
    checkOutput({tag, "_load_done"},  32'(load_done),  32'(d));
    checkOutput({tag, "_load_error"}, 32'(load_error), 32'(e));
    checkOutput({tag, "_cpu_reset"},  32'(cpu_reset),  32'(c));
    checkOutput({tag, "_nwrites"},    32'(write_q.size()), 32'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < write_q.size(); k++) begin
      checkOutput($sformatf("%s_addr%0d", tag, k), write_q[k].addr, exp_q[k].addr);
      checkOutput($sformatf("%s_data%0d", tag, k), write_q[k].data, exp_q[k].data);
    end
  endtask

  task automatic addVec(input string name, input int nbytes,
                        input logic [127:0] data, input int exp_writes,
                        input logic exp_done, input logic exp_error,
                        input logic exp_cpu_reset);
    vec_t v;
    v.name          = name;
    v.nbytes        = nbytes;
    v.data          = data;
    v.exp_writes    = exp_writes;
    v.exp_done      = exp_done;
    v.exp_error     = exp_error;
    v.exp_cpu_reset = exp_cpu_reset;
    vecs.push_back(v);
  endtask

  function automatic logic [7:0] noiseByte();
    logic [7:0] b;
    b = 8'($urandom_range(255, 0));
    if (b == SYNC) b = 8'h5A;
    return b;
  endfunction

  // Random session: noise, one to three frames of mixed kinds, noise.
  task automatic buildRandom(output logic [7:0] s[$]);
    int         kind;
    int         n;
    logic [7:0] x;
    logic [7:0] b;
    s = {};
    repeat ($urandom_range(3, 0)) s.push_back(noiseByte());
    repeat ($urandom_range(3, 1)) begin
      kind = int'($urandom_range(9, 0));
      s.push_back(SYNC);
      if (kind == 0) begin
        if ($urandom_range(1, 0) == 1) n = int'($urandom_range(40, MAX_WORDS + 1));
        else n = int'(($urandom_range(255, 1) << 8) | $urandom_range(255, 0));
        s.push_back(8'(n));
        s.push_back(8'(n >> 8));
      end else begin
        n = (kind == 1) ? 0 :
            (kind == 9) ? MAX_WORDS : int'($urandom_range(6, 1));
        s.push_back(8'(n));
        s.push_back(8'(n >> 8));
        x = 8'(n) ^ 8'(n >> 8);
        repeat (4 * n) begin
          b = 8'($urandom_range(255, 0));
          x = x ^ b;
          s.push_back(b);
        end
        if (kind == 2 || kind == 3) x = x ^ 8'($urandom_range(255, 1));
        s.push_back(x);
      end
      repeat ($urandom_range(2, 0)) s.push_back(noiseByte());
    end
  endtask

  logic [7:0] good_load [12] = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34,
                                 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h28};

  initial begin
    logic [7:0] s[$];
    logic [7:0] x;
    logic [7:0] b;

    addVec("good_load",   12, 128'hA5_02_00_78_56_34_12_EF_BE_AD_DE_28, 2, 1'b1, 1'b0, 1'b0);
    addVec("bad_chk",     12, 128'hA5_02_00_78_56_34_12_EF_BE_AD_DE_29, 2, 1'b0, 1'b1, 1'b1);
    addVec("zero_noise",   7, 128'h00_FF_5A_A5_00_00_00,                0, 1'b1, 1'b0, 1'b0);
    addVec("zero_reload",  8, 128'h00_FF_5A_A5_00_00_00_A5,             0, 1'b0, 1'b0, 1'b1);
    addVec("oversize",     5, 128'hA5_11_00_12_34,                      0, 1'b0, 1'b1, 1'b1);
    addVec("oversize_hi",  3, 128'hA5_00_01,                            0, 1'b0, 1'b1, 1'b1);
    addVec("one_word",     8, 128'hA5_01_00_44_33_22_11_45,             1, 1'b1, 1'b0, 1'b0);
    addVec("done_noise",  10, 128'hA5_01_00_44_33_22_11_45_00_5A,       1, 1'b1, 1'b0, 1'b0);
    addVec("two_frames",  16, 128'hA5_01_00_44_33_22_11_45_A5_01_00_DD_CC_BB_AA_01,
           2, 1'b1, 1'b0, 1'b0);
    addVec("sync_in_data", 8, 128'hA5_01_00_A5_A5_A5_A5_01,             1, 1'b1, 1'b0, 1'b0);

    @(negedge clk);
    applyReset();
    checkResetValues("reset");

    // Table vectors, bytes back-to-back.
    foreach (vecs[v]) begin
      applyReset();
      s = {};
      for (int i = 0; i < vecs[v].nbytes; i++) begin
        s.push_back(vecs[v].data[8*(vecs[v].nbytes-1-i) +: 8]);
      end
      runStream(s, 0, vecs[v].name);
      checkOutput({vecs[v].name, "_tbl_done"},  32'(load_done),  32'(vecs[v].exp_done));
      checkOutput({vecs[v].name, "_tbl_error"}, 32'(load_error), 32'(vecs[v].exp_error));
      checkOutput({vecs[v].name, "_tbl_cpu"},   32'(cpu_reset),  32'(vecs[v].exp_cpu_reset));
      checkOutput({vecs[v].name, "_tbl_nwr"},   32'(write_q.size()), 32'(vecs[v].exp_writes));
    end

    // Exact write, done and reload timing on the good frame.
    applyReset();
    for (int i = 0; i < 12; i++) begin
      applyStimulus(good_load[i], 0);
      if (i == 6) begin
        checkOutput("t_we0",   32'(mem_we),   32'd1);
        checkOutput("t_addr0", 32'(mem_addr), 32'd0);
        checkOutput("t_data0", mem_wdata,     32'h12345678);
      end
      if (i == 7) begin
        checkOutput("t_we0_end",  32'(mem_we), 32'd0);
        checkOutput("t_data0_hold", mem_wdata, 32'h12345678);
      end
      if (i == 10) begin
        checkOutput("t_we1",       32'(mem_we),    32'd1);
        checkOutput("t_addr1",     32'(mem_addr),  32'd1);
        checkOutput("t_data1",     mem_wdata,      32'hDEADBEEF);
        checkOutput("t_pre_done",  32'(load_done), 32'd0);
        checkOutput("t_pre_cpu",   32'(cpu_reset), 32'd1);
      end
      if (i == 11) begin
        checkOutput("t_done",      32'(load_done), 32'd1);
        checkOutput("t_cpu_run",   32'(cpu_reset), 32'd0);
        checkOutput("t_addr_hold", 32'(mem_addr),  32'd1);
      end
    end
    repeat (TIMEOUT_CLKS + 5) @(negedge clk);
    checkOutput("t_idle_no_error", 32'(load_error), 32'd0);
    checkOutput("t_idle_done",     32'(load_done),  32'd1);
    applyStimulus(SYNC, 0);
    checkOutput("t_reload_cpu",  32'(cpu_reset), 32'd1);
    checkOutput("t_reload_done", 32'(load_done), 32'd0);

    // Inter-byte timeout inside a data word, then a clean reload.
    applyReset();
    write_q.delete();
    applyStimulus(8'hA5, 0);
    applyStimulus(8'h01, 0);
    applyStimulus(8'h00, 0);
    applyStimulus(8'h11, 0);
    repeat (TIMEOUT_CLKS) @(negedge clk);
    checkOutput("to_not_yet", 32'(load_error), 32'd0);
    @(negedge clk);
    checkOutput("to_error",   32'(load_error), 32'd1);
    checkOutput("to_cpu",     32'(cpu_reset),  32'd1);
    checkOutput("to_nwrites", 32'(write_q.size()), 32'd0);
    runStream('{8'hA5, 8'h01, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'h45}, 0, "to_reload");
    checkOutput("to_reload_done", 32'(load_done), 32'd1);

    // Reset after the second byte of a data word.
    applyReset();
    write_q.delete();
    applyStimulus(8'hA5, 0);
    applyStimulus(8'h01, 0);
    applyStimulus(8'h00, 0);
    applyStimulus(8'h44, 0);
    applyStimulus(8'h33, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkResetValues("midrst");
    applyStimulus(8'h22, 0);
    applyStimulus(8'h11, 0);
    repeat (3) @(negedge clk);
    checkOutput("midrst_nwrites", 32'(write_q.size()), 32'd0);
    checkOutput("midrst_cpu",     32'(cpu_reset),      32'd1);
    runStream('{8'hA5, 8'h01, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'h45}, 1, "midrst_reload");
    checkOutput("midrst_reload_n", 32'(write_q.size()), 32'd1);
    if (write_q.size() >= 1) begin
      checkOutput("midrst_reload_data", write_q[0].data, 32'h11223344);
    end

    // Largest image that fits: 2**ADDR_W words.
    applyReset();
    s = {SYNC, 8'(MAX_WORDS), 8'h00};
    x = 8'(MAX_WORDS);
    repeat (4 * MAX_WORDS) begin
      b = 8'($urandom_range(255, 0));
      x = x ^ b;
      s.push_back(b);
    end
    s.push_back(x);
    runStream(s, 1, "max_img");
    checkOutput("max_img_n",    32'(write_q.size()), 32'(MAX_WORDS));
    checkOutput("max_img_done", 32'(load_done),      32'd1);
    checkOutput("max_img_last", 32'(mem_addr),       32'(MAX_WORDS - 1));

    // Randomised multi-frame sessions.
    for (int r = 0; r < 25; r++) begin
      applyReset();
      buildRandom(s);
      runStream(s, 3, $sformatf("rnd%0d", r));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
